// File: rtl/renkon_pool_window_if.sv
// renkon_pool_window_if: bundles the map handshake, the pixel stream and the window output.
//   req, fea_w, fea_h  : start a map of size fea_w x fea_h (master -> slave)
//   in_en, pixel_in    : raster-order input beats (master -> slave)
//   out_en, pixel_out  : window strobe and 3x3 window, row-major, [8] newest (slave -> master)
//   busy, ack          : map in progress / one-cycle completion pulse (slave -> master)
interface renkon_pool_window_if #(
    parameter int DWIDTH = 16,
    parameter int LWIDTH = 6
);
    logic                     req;
    logic [LWIDTH-1:0]        fea_w;
    logic [LWIDTH-1:0]        fea_h;
    logic                     in_en;
    logic signed [DWIDTH-1:0] pixel_in;
    logic                     out_en;
    logic signed [DWIDTH-1:0] pixel_out [9];
    logic                     busy;
    logic                     ack;

    modport master (
        output req, fea_w, fea_h, in_en, pixel_in,
        input  out_en, pixel_out, busy, ack
    );

    modport slave (
        input  req, fea_w, fea_h, in_en, pixel_in,
        output out_en, pixel_out, busy, ack
    );
endinterface

// File: rtl/renkon_pool_window.sv
// renkon_pool_window: 3x3 window generator on a stride grid, feeding the max-pool tree.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of renkon_pool_window_if (map handshake, pixel stream, window out)
module renkon_pool_window #(
    parameter int DWIDTH = 16,
    parameter int MAXW   = 32,
    parameter int LWIDTH = 6,
    parameter int STRIDE = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    renkon_pool_window_if.slave  bus
);
    localparam int AW = $clog2(MAXW);
    // Phase value at col/row 0 such that the phase reaches 0 exactly at index 2.
    localparam logic [1:0] PH0 = 2'((STRIDE - 2 % STRIDE) % STRIDE);
    localparam logic [1:0] PHL = 2'(STRIDE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e                   state_q;
    logic [LWIDTH-1:0]        w_q, h_q, col_q, row_q;
    logic [1:0]               cph_q, rph_q;
    logic                     out_en_q, busy_q, ack_q;
    logic signed [DWIDTH-1:0] win_q [9];
    logic signed [DWIDTH-1:0] win_d [9];
    logic signed [DWIDTH-1:0] pixel_out_q [9];
    logic signed [DWIDTH-1:0] lb1_q [MAXW];
    logic signed [DWIDTH-1:0] lb2_q [MAXW];
    logic                     beat, last_col, last_row, win_ok;
    logic [AW-1:0]            addr;

    assign addr     = col_q[AW-1:0];
    assign beat     = state_q == RUN && bus.in_en;
    assign last_col = col_q == w_q - LWIDTH'(1);
    assign last_row = row_q == h_q - LWIDTH'(1);
    assign win_ok   = col_q >= LWIDTH'(2) && row_q >= LWIDTH'(2) && cph_q == 2'd0 && rph_q == 2'd0;

    // Window chains: the newest column enters at the right of each row.
    always_comb begin
        win_d = win_q;
        if (beat) begin
            for (int r = 0; r < 3; r++) begin
                win_d[3*r]   = win_q[3*r+1];
                win_d[3*r+1] = win_q[3*r+2];
            end
            win_d[2] = lb2_q[addr];
            win_d[5] = lb1_q[addr];
            win_d[8] = bus.pixel_in;
        end
    end

    // Line buffer: both reads above see the old contents (read-before-write).
    always_ff @(posedge clk) begin
        if (beat) begin
            lb2_q[addr] <= lb1_q[addr];
            lb1_q[addr] <= bus.pixel_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            w_q      <= '0;
            h_q      <= '0;
            col_q    <= '0;
            row_q    <= '0;
            cph_q    <= '0;
            rph_q    <= '0;
            out_en_q <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i]       <= '0;
                pixel_out_q[i] <= '0;
            end
        end else begin
            win_q    <= win_d;
            out_en_q <= beat && win_ok;
            if (beat && win_ok)
                pixel_out_q <= win_d;
            ack_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.req) begin
                    state_q <= RUN;
                    busy_q  <= 1'b1;
                    w_q     <= bus.fea_w;
                    h_q     <= bus.fea_h;
                    col_q   <= '0;
                    row_q   <= '0;
                    cph_q   <= PH0;
                    rph_q   <= PH0;
                end
                RUN: if (beat) begin
                    col_q <= last_col ? '0 : col_q + LWIDTH'(1);
                    cph_q <= last_col ? PH0 : (cph_q == PHL ? 2'd0 : cph_q + 2'd1);
                    if (last_col) begin
                        row_q <= row_q + LWIDTH'(1);
                        rph_q <= rph_q == PHL ? 2'd0 : rph_q + 2'd1;
                    end
                    if (last_col && last_row) begin
                        state_q <= DONE;
                        ack_q   <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_en    = out_en_q;
    assign bus.pixel_out = pixel_out_q;
    assign bus.busy      = busy_q;
    assign bus.ack       = ack_q;
endmodule

// File: tb/tb_renkon_pool_window.sv
// tb_renkon_pool_window: directed maps against a window model, plus literal pins of the model.
module tb_renkon_pool_window;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    renkon_pool_window_if #(.DWIDTH(16), .LWIDTH(6)) bus2 ();
    renkon_pool_window_if #(.DWIDTH(16), .LWIDTH(6)) bus1 ();

    renkon_pool_window #(.DWIDTH(16), .MAXW(32), .LWIDTH(6), .STRIDE(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );
    renkon_pool_window #(.DWIDTH(16), .MAXW(32), .LWIDTH(6), .STRIDE(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int                sel;
    logic              req_b, in_en_b;
    logic [5:0]        fw, fh;
    logic signed [15:0] pin;

    assign bus2.req      = req_b && sel == 0;
    assign bus1.req      = req_b && sel == 1;
    assign bus2.in_en    = in_en_b && sel == 0;
    assign bus1.in_en    = in_en_b && sel == 1;
    assign bus2.fea_w    = fw;
    assign bus1.fea_w    = fw;
    assign bus2.fea_h    = fh;
    assign bus1.fea_h    = fh;
    assign bus2.pixel_in = pin;
    assign bus1.pixel_in = pin;

    logic               oe [2];
    logic               bz [2];
    logic               ak [2];
    logic signed [15:0] po [2][9];
    always_comb begin
        oe[0] = bus2.out_en; bz[0] = bus2.busy; ak[0] = bus2.ack;
        oe[1] = bus1.out_en; bz[1] = bus1.busy; ak[1] = bus1.ack;
        for (int k = 0; k < 9; k++) begin
            po[0][k] = bus2.pixel_out[k];
            po[1][k] = bus1.pixel_out[k];
        end
    end

    logic               exp_en [2];
    logic               exp_busy [2];
    logic               exp_ack [2];
    logic signed [15:0] exp_win [2][9];
    logic               chk;
    int                 vectors, miscompares;
    int                 img [32][32];

    logic [143:0] cap[$];
    logic [143:0] s1[$];
    int           maxq[$];
    int           n_en, n_ack, ack_with_en;

    // Per-cycle compare of both instances against the model expectations.
    always @(negedge clk) begin
        logic         bad;
        logic [143:0] gw, ew;
        int           mx;
        if (chk) begin
            for (int d = 0; d < 2; d++) begin
                gw = '0;
                ew = '0;
                for (int k = 0; k < 9; k++) begin
                    gw[16*(8-k) +: 16] = po[d][k];
                    ew[16*(8-k) +: 16] = exp_win[d][k];
                end
                bad = oe[d] !== exp_en[d] || bz[d] !== exp_busy[d] || ak[d] !== exp_ack[d] || gw !== ew;
                vectors++;
                if (bad) begin
                    miscompares++;
                    $display("FAIL cycle dut%0d t=%0t: out_en=%b busy=%b ack=%b win=%h, want out_en=%b busy=%b ack=%b win=%h",
                             d, $time, oe[d], bz[d], ak[d], gw, exp_en[d], exp_busy[d], exp_ack[d], ew);
                end
                if (d == sel) begin
                    if (oe[d] === 1'b1) begin
                        cap.push_back(gw);
                        mx = int'(po[d][0]);
                        for (int k = 1; k < 9; k++)
                            if (int'(po[d][k]) > mx) mx = int'(po[d][k]);
                        maxq.push_back(mx);
                        n_en++;
                    end
                    if (ak[d] === 1'b1) begin
                        n_ack++;
                        if (oe[d] === 1'b1) ack_with_en++;
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [143:0] got, input logic [143:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic clear_cap();
        cap.delete();
        maxq.delete();
        n_en = 0;
        n_ack = 0;
        ack_with_en = 0;
    endtask

    function automatic logic [143:0] capi(input int i);
        return i < cap.size() ? cap[i] : '1;
    endfunction

    function automatic int maxi(input int i);
        return i < maxq.size() ? maxq[i] : -1;
    endfunction

    function automatic bit wvalid(input int r, input int c, input int s);
        return r >= 2 && c >= 2 && (r - 2) % s == 0 && (c - 2) % s == 0;
    endfunction

    // Streams img[0..h-1][0..w-1] into dut d and sets the expected outputs for each cycle.
    task automatic run_map(input int d, input int w, input int h, input bit gap, input int rst_at);
        int s, nb;
        s = d == 0 ? 2 : 1;
        nb = 0;
        sel = d;
        fw = 6'(w);
        fh = 6'(h);
        req_b = 1'b1;
        in_en_b = 1'b1;
        pin = 16'sh7bad;
        cyc();
        req_b = 1'b0;
        exp_busy[d] = 1'b1;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                while (gap && $urandom_range(0, 1) == 0) begin
                    in_en_b = 1'b0;
                    pin = 16'($urandom);
                    cyc();
                    exp_en[d] = 1'b0;
                end
                in_en_b = 1'b1;
                pin = 16'(img[r][c]);
                cyc();
                nb++;
                exp_en[d] = wvalid(r, c, s);
                if (exp_en[d])
                    for (int k = 0; k < 9; k++)
                        exp_win[d][k] = 16'(img[r - 2 + k / 3][c - 2 + k % 3]);
                exp_ack[d] = r == h - 1 && c == w - 1;
                if (nb == rst_at) begin
                    rst = 1'b1;
                    pin = 16'sh1234;
                    cyc();
                    rst = 1'b0;
                    in_en_b = 1'b0;
                    for (int e = 0; e < 2; e++) begin
                        exp_en[e] = 1'b0;
                        exp_busy[e] = 1'b0;
                        exp_ack[e] = 1'b0;
                        for (int k = 0; k < 9; k++) exp_win[e][k] = '0;
                    end
                    return;
                end
            end
        end
        // DONE cycle: a req or beat here must be ignored.
        req_b = 1'b1;
        in_en_b = 1'b1;
        pin = 16'sh7bad;
        cyc();
        req_b = 1'b0;
        in_en_b = 1'b0;
        exp_en[d] = 1'b0;
        exp_ack[d] = 1'b0;
        exp_busy[d] = 1'b0;
    endtask

    initial begin
        logic [143:0] z;
        vectors = 0;
        miscompares = 0;
        chk = 1'b0;
        sel = 0;
        req_b = 1'b0;
        in_en_b = 1'b0;
        fw = '0;
        fh = '0;
        pin = '0;
        clear_cap();
        for (int d = 0; d < 2; d++) begin
            exp_en[d] = 1'b0;
            exp_busy[d] = 1'b0;
            exp_ack[d] = 1'b0;
            for (int k = 0; k < 9; k++) exp_win[d][k] = '0;
        end
        rst = 1'b1;
        cyc();
        cyc();
        chk = 1'b1;
        rst = 1'b0;
        check("reset flags", 144'({oe[0], bz[0], ak[0], oe[1], bz[1], ak[1]}), '0);

        // 5x5, stride 2, dense input.
        for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) img[r][c] = 5 * r + c;
        clear_cap();
        run_map(0, 5, 5, 1'b0, 0);
        check("s1 window count", 144'(n_en), 144'(4));
        check("s1 first window", capi(0),
              {16'd0, 16'd1, 16'd2, 16'd5, 16'd6, 16'd7, 16'd10, 16'd11, 16'd12});
        check("s1 pool maxima", 144'({maxi(0), maxi(1), maxi(2), maxi(3)}),
              144'({32'd12, 32'd14, 32'd22, 32'd24}));
        check("s1 ack with 4th out_en", 144'(ack_with_en), 144'(1));
        s1 = cap;

        // Same map with random input gaps.
        clear_cap();
        run_map(0, 5, 5, 1'b1, 0);
        check("s2 window count", 144'(n_en), 144'(4));
        for (int i = 0; i < 4; i++) check($sformatf("s2 window %0d", i), capi(i), s1[i]);

        // Stride 1, 4 wide by 3 high.
        for (int r = 0; r < 3; r++) for (int c = 0; c < 4; c++) img[r][c] = 4 * r + c;
        clear_cap();
        run_map(1, 4, 3, 1'b0, 0);
        check("s3 window count", 144'(n_en), 144'(2));
        check("s3 second window", capi(1),
              {16'd1, 16'd2, 16'd3, 16'd5, 16'd6, 16'd7, 16'd9, 16'd10, 16'd11});

        // 2x2 map then an immediate 3x3 map.
        for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) img[r][c] = 100 + 2 * r + c;
        clear_cap();
        run_map(0, 2, 2, 1'b0, 0);
        check("s4 2x2 window count", 144'(n_en), 144'(0));
        check("s4 2x2 ack count", 144'(n_ack), 144'(1));
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) img[r][c] = 20 + 3 * r + c;
        clear_cap();
        run_map(0, 3, 3, 1'b0, 0);
        check("s4 3x3 window count", 144'(n_en), 144'(1));
        check("s4 3x3 window", capi(0),
              {16'd20, 16'd21, 16'd22, 16'd23, 16'd24, 16'd25, 16'd26, 16'd27, 16'd28});

        // Negative pixels.
        for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) img[r][c] = -5 + 3 * r + c;
        clear_cap();
        run_map(0, 3, 3, 1'b0, 0);
        check("s5 signed window", capi(0),
              {-16'sd5, -16'sd4, -16'sd3, -16'sd2, -16'sd1, 16'sd0, 16'sd1, 16'sd2, 16'sd3});
        check("s5 pool max", 144'(maxi(0)), 144'(3));

        // Reset after the 13th beat, then a fresh map.
        for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) img[r][c] = 5 * r + c;
        clear_cap();
        run_map(0, 5, 5, 1'b0, 13);
        z = '0;
        for (int k = 0; k < 9; k++) z[16*(8-k) +: 16] = po[0][k];
        check("s6 flags after rst", 144'({oe[0], bz[0], ak[0]}), '0);
        check("s6 window after rst", z, '0);
        clear_cap();
        run_map(0, 5, 5, 1'b0, 0);
        check("s6 window count", 144'(n_en), 144'(4));
        for (int i = 0; i < 4; i++) check($sformatf("s6 window %0d", i), capi(i), s1[i]);
        check("s6 pool maxima", 144'({maxi(0), maxi(1), maxi(2), maxi(3)}),
              144'({32'd12, 32'd14, 32'd22, 32'd24}));

        cyc();
        cyc();
        chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
